// File: rtl/axis_wrr_mux.sv
// axis_wrr_mux: S_COUNT-input AXI4-Stream packet mux with weighted round-robin
// arbitration and per-port runtime weights.
//
// Valid/ready contract on every AXI4-Stream interface: a beat moves on a rising
// clk edge where tvalid and tready are both high. A source holds its beat stable
// while tvalid is high and tready is low. s_axis_tready comes only from
// registers, so there is no combinational path from m_axis_tready to it.
//
// The grant is held for a whole packet. A granted port may send up to
// weight[port] packets back-to-back before the grant rotates. Weight 0 disables
// a port. Between two packets there is always one idle cycle, which is the IDLE
// arbitration cycle.
//
// FSM state is visible on grant_valid (high in GRANT, low in IDLE) and on
// grant_encoded.
//
// Optional feature, enabled by defining AXIS_WRR_MUX_STATS_EN: per-port
// saturating 32-bit packet counters (stat_pkts) with a synchronous clear
// (stat_clr).
module axis_wrr_mux #(
  parameter int S_COUNT      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH   = (DATA_WIDTH + 7) / 8,
  parameter bit ID_ENABLE    = 1'b0,
  parameter int ID_WIDTH     = 8,
  parameter bit USER_ENABLE  = 1'b1,
  parameter int USER_WIDTH   = 1,
  parameter bit LAST_ENABLE  = 1'b1,
  parameter int WEIGHT_WIDTH = 4,
  localparam int SEL_WIDTH   = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]     s_axis_tid,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] weight,
  output logic                            grant_valid,
  output logic [SEL_WIDTH-1:0]            grant_encoded
`ifdef AXIS_WRR_MUX_STATS_EN
  ,
  input  logic                            stat_clr,
  output logic [S_COUNT*32-1:0]           stat_pkts
`endif
);

  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + USER_WIDTH + 1;

  typedef enum logic [0:0] {ST_IDLE, ST_GRANT} state_t;

  state_t                  state;
  logic [SEL_WIDTH-1:0]    grant_reg;
  logic [SEL_WIDTH-1:0]    ptr_reg;
  logic [WEIGHT_WIDTH-1:0] credit_reg;

  logic [S_COUNT-1:0]      eligible;
  logic                    arb_found;
  logic [SEL_WIDTH-1:0]    arb_sel;
  logic [SEL_WIDTH-1:0]    cand;
  logic [WEIGHT_WIDTH-1:0] arb_weight;

  logic                    ready_int_reg;
  logic                    ready_int_early;
  logic                    s_valid_int;
  logic                    pkt_done;

  logic [DATA_WIDTH-1:0]   beat_data;
  logic [KEEP_WIDTH-1:0]   beat_keep;
  logic [ID_WIDTH-1:0]     beat_id;
  logic [USER_WIDTH-1:0]   beat_user;
  logic                    beat_last;
  logic [BEAT_W-1:0]       int_beat;

  logic                    m_valid_reg, m_valid_next;
  logic                    temp_valid_reg, temp_valid_next;
  logic [BEAT_W-1:0]       m_beat_reg;
  logic [BEAT_W-1:0]       temp_beat_reg;
  logic                    store_int_to_output;
  logic                    store_int_to_temp;
  logic                    store_temp_to_output;

  // A port competes only while it is presenting data and has a nonzero weight.
  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      eligible[i] = s_axis_tvalid[i] && (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end
  end

  // Round-robin search: first eligible port strictly after the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    cand      = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      cand = SEL_WIDTH'((int'(ptr_reg) + k) % S_COUNT);
      if (!arb_found && eligible[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  assign arb_weight = weight[arb_sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];

  // Beat selected from the granted port. Disabled sideband fields get constants.
  assign beat_data = s_axis_tdata[grant_reg*DATA_WIDTH +: DATA_WIDTH];
  assign beat_keep = KEEP_ENABLE ? s_axis_tkeep[grant_reg*KEEP_WIDTH +: KEEP_WIDTH]
                                 : {KEEP_WIDTH{1'b1}};
  assign beat_id   = ID_ENABLE ? s_axis_tid[grant_reg*ID_WIDTH +: ID_WIDTH] : '0;
  assign beat_user = USER_ENABLE ? s_axis_tuser[grant_reg*USER_WIDTH +: USER_WIDTH] : '0;
  assign beat_last = LAST_ENABLE ? s_axis_tlast[grant_reg] : 1'b1;
  assign int_beat  = {beat_data, beat_keep, beat_id, beat_user, beat_last};

  // Beat accepted from the granted port this cycle.
  assign s_valid_int = (state == ST_GRANT) && s_axis_tvalid[grant_reg] && ready_int_reg;
  assign pkt_done    = s_valid_int && beat_last;

  // Only the granted port sees tready, and only while the FSM is in GRANT.
  always_comb begin
    s_axis_tready = '0;
    if (state == ST_GRANT) begin
      s_axis_tready[grant_reg] = ready_int_reg;
    end
  end

  // Arbitration FSM. A remaining credit re-grants the last port first.
  // Otherwise the grant rotates and the credit reloads from the weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_reg  <= '0;
      ptr_reg    <= SEL_WIDTH'(S_COUNT - 1);
      credit_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eligible[grant_reg] && (credit_reg != '0)) begin
            credit_reg <= credit_reg - 1'b1;
            state      <= ST_GRANT;
          end else if (arb_found) begin
            grant_reg  <= arb_sel;
            ptr_reg    <= arb_sel;
            credit_reg <= arb_weight - 1'b1;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (pkt_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign grant_valid   = (state == ST_GRANT);
  assign grant_encoded = grant_reg;

  // Skid steering. The output register is loaded when it is free or draining.
  // The temp register catches the beat already in flight when the output stalls.
  always_comb begin
    m_valid_next         = m_valid_reg;
    temp_valid_next      = temp_valid_reg;
    store_int_to_output  = 1'b0;
    store_int_to_temp    = 1'b0;
    store_temp_to_output = 1'b0;
    if (ready_int_reg) begin
      if (m_axis_tready || !m_valid_reg) begin
        m_valid_next        = s_valid_int;
        store_int_to_output = 1'b1;
      end else begin
        temp_valid_next   = s_valid_int;
        store_int_to_temp = 1'b1;
      end
    end else if (m_axis_tready) begin
      m_valid_next         = temp_valid_reg;
      temp_valid_next      = 1'b0;
      store_temp_to_output = 1'b1;
    end
  end

  // Early ready: accept next cycle if the output drains or the temp slot stays free.
  assign ready_int_early = m_axis_tready || (!temp_valid_reg && (!m_valid_reg || !s_valid_int));

  // Skid valid flags and registered internal ready. Reset empties the skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg    <= 1'b0;
      temp_valid_reg <= 1'b0;
      ready_int_reg  <= 1'b0;
    end else begin
      m_valid_reg    <= m_valid_next;
      temp_valid_reg <= temp_valid_next;
      ready_int_reg  <= ready_int_early;
    end
  end

  // Skid payload registers. Their contents matter only while the matching valid is set.
  always_ff @(posedge clk) begin
    if (store_int_to_output) begin
      m_beat_reg <= int_beat;
    end else if (store_temp_to_output) begin
      m_beat_reg <= temp_beat_reg;
    end
    if (store_int_to_temp) begin
      temp_beat_reg <= int_beat;
    end
  end

  assign m_axis_tvalid = m_valid_reg;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tuser, m_axis_tlast} = m_beat_reg;

`ifdef AXIS_WRR_MUX_STATS_EN
  logic [31:0] stat_cnt [S_COUNT];

  // Per-port packet counters. A clear takes priority over a same-cycle increment.
  // Counts saturate at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < S_COUNT; i++) stat_cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < S_COUNT; i++) stat_cnt[i] <= '0;
    end else if (pkt_done && (stat_cnt[grant_reg] != '1)) begin
      stat_cnt[grant_reg] <= stat_cnt[grant_reg] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_stat
    assign stat_pkts[gi*32 +: 32] = stat_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_axis_wrr_mux.sv
// Directed bench for axis_wrr_mux (default parameters: 4 ports, 8-bit data).
// Sources replay per-port beat tables. Each expected output order is written by
// hand into a scoreboard queue, and a negedge monitor checks every output beat.
module tb_axis_wrr_mux;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int WW = 4;

  logic            clk;
  logic            rst_n;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S-1:0]    s_axis_tkeep;
  logic [S-1:0]    s_axis_tvalid;
  logic [S-1:0]    s_axis_tready;
  logic [S-1:0]    s_axis_tlast;
  logic [S*8-1:0]  s_axis_tid;
  logic [S-1:0]    s_axis_tuser;
  logic [DW-1:0]   m_axis_tdata;
  logic [0:0]      m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [7:0]      m_axis_tid;
  logic [0:0]      m_axis_tuser;
  logic [S*WW-1:0] weight;
  logic            grant_valid;
  logic [1:0]      grant_encoded;
`ifdef AXIS_WRR_MUX_STATS_EN
  logic            stat_clr;
  logic [S*32-1:0] stat_pkts;
`endif

  axis_wrr_mux dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tuser  (m_axis_tuser),
    .weight        (weight),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded)
`ifdef AXIS_WRR_MUX_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_pkts     (stat_pkts)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int checks   = 0;
  int failures = 0;

  // Beat format {last, user, data}; data = {port[1:0], seq[5:0]}.
  logic [9:0] exp_q[$];
  logic [9:0] src_mem [S][64];
  int         src_cnt [S];
  int         src_idx [S];
  int         src_seq [S];
  int         exp_seq [S];
  int         src_pkts[S];
  bit         bp_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] make_beat(input int p, input int seq, input bit last);
    logic [1:0] pp;
    logic [5:0] ss;
    pp = p[1:0];
    ss = seq[5:0];
    return {last, ss[0] ^ pp[0], pp, ss};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) begin
      src_mem[p][src_cnt[p]] = make_beat(p, src_seq[p], b == len - 1);
      src_cnt[p]++;
      src_seq[p]++;
    end
  endtask

  task automatic expect_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) begin
      exp_q.push_back(make_beat(p, exp_seq[p], b == len - 1));
      exp_seq[p]++;
    end
  endtask

  task automatic clear_sources();
    for (int p = 0; p < S; p++) begin
      src_cnt[p]  = 0;
      src_idx[p]  = 0;
      src_seq[p]  = 0;
      exp_seq[p]  = 0;
      src_pkts[p] = 0;
    end
    exp_q.delete();
  endtask

  task automatic enter_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_sources();
  endtask

  task automatic leave_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Source process: records handshakes at negedge, advances the tables after the
  // next posedge, and drives the next beats and m_axis_tready.
  initial begin
    logic [S-1:0] fire;
    logic [9:0]   bt;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    s_axis_tkeep  = '1;
    s_axis_tid    = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < S; p++) begin
        if (fire[p] && src_idx[p] < src_cnt[p]) begin
          if (src_mem[p][src_idx[p]][9]) src_pkts[p]++;
          src_idx[p]++;
        end
        if (src_idx[p] < src_cnt[p]) begin
          bt = src_mem[p][src_idx[p]];
          s_axis_tvalid[p]        = 1'b1;
          s_axis_tdata[p*DW +: DW] = bt[7:0];
          s_axis_tuser[p]         = bt[8];
          s_axis_tlast[p]         = bt[9];
          s_axis_tid[p*8 +: 8]    = 8'(8'hA0 + p);
        end else begin
          s_axis_tvalid[p] = 1'b0;
        end
      end
      m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [9:0] got;
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
        got = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got=%0h expected=none at %0t", got, $time);
        end else begin
          exp = exp_q.pop_front();
          check("beat", 32'(got), 32'(exp));
        end
        check("tkeep_ones", 32'(m_axis_tkeep), 32'd1);
        check("tid_zero", 32'(m_axis_tid), 32'd0);
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int order3 [6] = '{0, 0, 0, 1, 3, 3};
    int order5 [6] = '{0, 0, 0, 0, 1, 0};
    rst_n  = 1'b0;
    weight = '0;
`ifdef AXIS_WRR_MUX_STATS_EN
    stat_clr = 1'b0;
`endif
    clear_sources();
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_enc", 32'(grant_encoded), 32'd0);

    // Reset arrives in the middle of an 8-beat packet on port 0.
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    load_pkt(0, 8);
    expect_pkt(0, 8);
    leave_reset();
    n = 0;
    while (src_idx[0] < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_started", 32'(src_idx[0] >= 3), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_m_tvalid_async", 32'(m_axis_tvalid), 32'd0);
    check("t1_s_tready_async", 32'(s_axis_tready), 32'd0);
    check("t1_grant_valid_async", 32'(grant_valid), 32'd0);
    clear_sources();
    load_pkt(1, 1);
    load_pkt(0, 1);
    expect_pkt(0, 1);
    expect_pkt(1, 1);
    leave_reset();
    n = 0;
    while (!grant_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_first_grant_valid", 32'(grant_valid), 32'd1);
    check("t1_first_grant_port0", 32'(grant_encoded), 32'd0);
    wait_drain("t1_drain", 200);

    // Equal weights: single-beat packets rotate 0,1,2,3,0,1,2,3.
    enter_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int p = 0; p < S; p++) load_pkt(p, 1);
    for (int p = 0; p < S; p++) load_pkt(p, 1);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < S; p++) expect_pkt(p, 1);
    leave_reset();
    wait_drain("t2_drain", 300);

    // Weights {3,1,0,2}: two rounds of 0,0,0,1,3,3. Port 2 is valid but never granted.
    enter_reset();
    weight = {4'd2, 4'd0, 4'd1, 4'd3};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++) begin
        load_pkt(order3[i], 1);
        expect_pkt(order3[i], 1);
      end
    load_pkt(2, 1);
    load_pkt(2, 1);
    leave_reset();
    wait_drain("t3_drain", 400);
    check("t3_p2_never_sent", 32'(src_idx[2]), 32'd0);

    // Random output backpressure on 8-beat packets with equal weights.
    enter_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    bp_mode = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < S; p++) begin
        load_pkt(p, 8);
        expect_pkt(p, 8);
      end
    leave_reset();
    wait_drain("t4_drain", 2000);
    bp_mode = 1'b0;

    // Port 0 weight 4; port 1 appears after port 0's second packet.
    // Expected order: 0,0,0,0,1,0.
    enter_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd4};
    for (int i = 0; i < 5; i++) load_pkt(0, 2);
    for (int i = 0; i < 6; i++) expect_pkt(order5[i], 2);
    leave_reset();
    n = 0;
    while (src_pkts[0] < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_p0_two_pkts", 32'(src_pkts[0] >= 2), 32'd1);
    load_pkt(1, 2);
    wait_drain("t5_drain", 500);

`ifdef AXIS_WRR_MUX_STATS_EN
    // Five packets on port 2, then a clear pulsed alongside a sixth tlast beat.
    enter_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 5; i++) begin
      load_pkt(2, 1);
      expect_pkt(2, 1);
    end
    leave_reset();
    wait_drain("t6_drain", 300);
    check("t6_stat_p2_five", stat_pkts[2*32 +: 32], 32'd5);
    check("t6_stat_p0_zero", stat_pkts[0 +: 32], 32'd0);
    load_pkt(2, 1);
    expect_pkt(2, 1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (s_axis_tvalid[2] && s_axis_tready[2]) begin
        stat_clr = 1'b1;
        break;
      end
    end
    check("t6_clr_aligned", 32'(stat_clr), 32'd1);
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    @(negedge clk);
    check("t6_stat_p2_cleared", stat_pkts[2*32 +: 32], 32'd0);
    wait_drain("t6_drain2", 100);
    check("t6_stat_p2_still_zero", stat_pkts[2*32 +: 32], 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
